fsm_table_controller: RTL and testbench

FSM_TABLE_CONTROLLER -- requirements
Module: fsm_table_controller

---
 rtl/fsm_table_controller.sv | 232 +++++++++++++++++++++++
 tb/tb_fsm_table_controller.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_table_controller.sv
// ---------------------------------------------------------------------------
// fsm_table_controller
//
// A small run-time programmable overlay FSM. A CPU programs a 16-entry
// transition table over a simple valid/ready register bus, then starts the
// machine. Each input event selects column 0 or 1 of the current state's
// table entry, which gives the next state and a 4-bit output nibble.
// Reaching the programmed halt state stops the machine.
//
// Ports
//   clk            system clock, all state changes on the rising edge
//   rst            synchronous active-high reset
//   bus_valid      CPU access request, held until bus_ready
//   bus_we         1 = write, 0 = read
//   bus_addr[5:0]  word address
//   bus_wdata[31:0] write data
//   bus_ready      one-cycle completion pulse, one cycle after request
//   bus_rdata[31:0] read data while bus_ready=1, otherwise 0
//   ev_valid       event strobe for the running FSM
//   ev_bit         event value, selects table column 0/1
//   fsm_state[3:0] current overlay state (INIT_STATE while idle)
//   fsm_config_out[3:0] output nibble of the last transition taken
//   running        high while the controller is in RUN
//
// Register map
//   0x00 CTRL       [0] RUN (reads back running), [1] CLR_ERR (write-1)
//   0x01 STATUS     [3:0] state, [4] running, [5] halted, [6] wr_err,
//                   [15:8] step_cnt
//   0x02 INIT_STATE [3:0]
//   0x03 HALT_STATE [3:0]
//   0x10-0x1F TABLE [3:0] next0, [7:4] out0, [11:8] next1, [15:12] out1
// ---------------------------------------------------------------------------
module fsm_table_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_valid,
  input  logic        bus_we,
  input  logic [5:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic        bus_ready,
  output logic [31:0] bus_rdata,
  input  logic        ev_valid,
  input  logic        ev_bit,
  output logic [3:0]  fsm_state,
  output logic [3:0]  fsm_config_out,
  output logic        running
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } ctrl_state_e;

  ctrl_state_e state_q, state_d;

  logic        bus_ready_q;
  logic [31:0] rdata_q;
  logic [3:0]  cur_q;
  logic [3:0]  cfg_q;
  logic [7:0]  step_q;
  logic        err_q;
  logic [3:0]  init_q;
  logic [3:0]  halt_q;
  logic [15:0] table_q [16];

  logic        halted;
  logic        access;
  logic        wr_acc;
  logic        rd_acc;
  logic        sel_ctrl;
  logic        sel_status;
  logic        sel_init;
  logic        sel_halt;
  logic        sel_tbl;
  logic        ctrl_wr;
  logic        cfg_wr;
  logic        cfg_wr_ok;
  logic        cfg_wr_rej;
  logic        restart;
  logic        ev_take;
  logic [15:0] entry;
  logic [3:0]  ev_next;
  logic [3:0]  ev_out;
  logic [31:0] rd_val;

  // Upper write-data bits are never stored anywhere.
  logic unused_wdata;
  assign unused_wdata = ^bus_wdata[31:16];

  // A request is accepted on the first edge it is seen; the ready pulse
  // that follows blocks re-acceptance of the same (still held) request.
  assign access = bus_valid && !bus_ready_q;
  assign wr_acc = access && bus_we;
  assign rd_acc = access && !bus_we;

  assign sel_ctrl   = (bus_addr == 6'h00);
  assign sel_status = (bus_addr == 6'h01);
  assign sel_init   = (bus_addr == 6'h02);
  assign sel_halt   = (bus_addr == 6'h03);
  assign sel_tbl    = (bus_addr[5:4] == 2'b01);

  assign ctrl_wr    = wr_acc && sel_ctrl;
  assign cfg_wr     = wr_acc && (sel_init || sel_halt || sel_tbl);
  // Configuration is frozen while the machine runs.
  assign cfg_wr_ok  = cfg_wr && (state_q != S_RUN);
  assign cfg_wr_rej = cfg_wr && (state_q == S_RUN);

  // RUN=1 from IDLE or HALT (re)starts at INIT_STATE; in RUN it is a no-op.
  assign restart = ctrl_wr && bus_wdata[0] && (state_q != S_RUN);

  // A CTRL write in the same cycle as an event wins; the event is dropped.
  assign ev_take = (state_q == S_RUN) && ev_valid && !ctrl_wr;

  assign entry   = table_q[cur_q];
  assign ev_next = ev_bit ? entry[11:8]  : entry[3:0];
  assign ev_out  = ev_bit ? entry[15:12] : entry[7:4];

  // ---------------------------------------------------------------- FSM --
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ctrl_wr && bus_wdata[0]) state_d = S_RUN;
      end
      S_RUN: begin
        if (ctrl_wr && !bus_wdata[0]) begin
          state_d = S_IDLE;
        end else if (ev_take && (ev_next == halt_q)) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (ctrl_wr) state_d = bus_wdata[0] ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    running        = (state_q == S_RUN);
    halted         = (state_q == S_HALT);
    // While idle the visible state tracks INIT_STATE, so reprogramming it
    // is observable before RUN is set.
    fsm_state      = (state_q == S_IDLE) ? init_q : cur_q;
    fsm_config_out = cfg_q;
    bus_ready      = bus_ready_q;
    bus_rdata      = rdata_q;
  end

  // ----------------------------------------------------------- datapath --
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q  <= 4'h0;
      cfg_q  <= 4'h0;
      step_q <= 8'h00;
    end else if (restart) begin
      cur_q  <= init_q;
      step_q <= 8'h00;
    end else if (ev_take) begin
      cur_q  <= ev_next;
      cfg_q  <= ev_out;
      step_q <= step_q + 8'd1;
    end
  end

  // A rejected write sets the flag even if a clear arrives in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (cfg_wr_rej) begin
      err_q <= 1'b1;
    end else if (ctrl_wr && bus_wdata[1]) begin
      err_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_q <= 4'h0;
      halt_q <= 4'hF;
      for (int i = 0; i < 16; i++) begin
        table_q[i] <= 16'h0000;
      end
    end else if (cfg_wr_ok) begin
      if (sel_init) init_q <= bus_wdata[3:0];
      if (sel_halt) halt_q <= bus_wdata[3:0];
      if (sel_tbl)  table_q[bus_addr[3:0]] <= bus_wdata[15:0];
    end
  end

  // ---------------------------------------------------------------- bus --
  always_comb begin
    rd_val = 32'h0;
    if (sel_ctrl) begin
      rd_val[0] = running;
    end else if (sel_status) begin
      rd_val[3:0]  = fsm_state;
      rd_val[4]    = running;
      rd_val[5]    = halted;
      rd_val[6]    = err_q;
      rd_val[15:8] = step_q;
    end else if (sel_init) begin
      rd_val[3:0] = init_q;
    end else if (sel_halt) begin
      rd_val[3:0] = halt_q;
    end else if (sel_tbl) begin
      rd_val[15:0] = table_q[bus_addr[3:0]];
    end
  end

  // Read data is captured at acceptance and only presented during the
  // ready pulse; writes complete with zero data.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_ready_q <= 1'b0;
      rdata_q     <= 32'h0;
    end else begin
      bus_ready_q <= access;
      rdata_q     <= rd_acc ? rd_val : 32'h0;
    end
  end

endmodule

// File: tb/tb_fsm_table_controller.sv
module tb_fsm_table_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_valid;
  logic        bus_we;
  logic [5:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        ev_valid;
  logic        ev_bit;
  logic [3:0]  fsm_state;
  logic [3:0]  fsm_config_out;
  logic        running;

  always #5 clk = ~clk;

  fsm_table_controller dut (
    .clk            (clk),
    .rst            (rst),
    .bus_valid      (bus_valid),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_ready      (bus_ready),
    .bus_rdata      (bus_rdata),
    .ev_valid       (ev_valid),
    .ev_bit         (ev_bit),
    .fsm_state      (fsm_state),
    .fsm_config_out (fsm_config_out),
    .running        (running)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  bit rnd_ev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model --------------------------
  // mode: 0 = idle, 1 = run, 2 = halt
  int          m_mode, m_cur, m_cfg, m_step, m_init, m_halt;
  int          m_tbl [16];
  bit          m_err, m_ready;
  logic [31:0] exp_q [$];

  int old_mode, mi_a, mi_e, mi_nxt, mi_out;
  bit mi_acc, mi_ctrl;

  function automatic int m_vis();
    return (m_mode == 0) ? m_init : m_cur;
  endfunction

  function automatic logic [31:0] m_read(input int a);
    logic [31:0] r;
    r = 32'h0;
    if (a == 0) r = (m_mode == 1) ? 32'h1 : 32'h0;
    else if (a == 1)
      r = 32'(m_vis()) + ((m_mode == 1) ? 32'h10 : 32'h0) + ((m_mode == 2) ? 32'h20 : 32'h0)
          + (m_err ? 32'h40 : 32'h0) + 32'(m_step * 256);
    else if (a == 2) r = 32'(m_init);
    else if (a == 3) r = 32'(m_halt);
    else if (a >= 16 && a < 32) r = 32'(m_tbl[a - 16]);
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_cur = 0; m_cfg = 0; m_step = 0;
      m_init = 0; m_halt = 15; m_err = 1'b0; m_ready = 1'b0;
      for (int i = 0; i < 16; i++) m_tbl[i] = 0;
      exp_q.delete();
    end else begin
      old_mode = m_mode;
      mi_a     = int'(bus_addr);
      mi_acc   = bus_valid && !m_ready;
      mi_ctrl  = mi_acc && bus_we && (mi_a == 0);
      if (mi_acc) exp_q.push_back(bus_we ? 32'h0 : m_read(mi_a));
      m_ready = mi_acc;
      // event in RUN, unless a CTRL write claims this cycle
      if (old_mode == 1 && ev_valid && !mi_ctrl) begin
        mi_e   = m_tbl[m_cur];
        mi_nxt = ev_bit ? (mi_e / 256) % 16 : mi_e % 16;
        mi_out = ev_bit ? (mi_e / 4096) % 16 : (mi_e / 16) % 16;
        m_cur  = mi_nxt;
        m_cfg  = mi_out;
        m_step = (m_step + 1) % 256;
        if (mi_nxt == m_halt) m_mode = 2;
      end
      if (mi_acc && bus_we) begin
        if (mi_a == 0) begin
          if (bus_wdata[1]) m_err = 1'b0;
          if (bus_wdata[0] && old_mode != 1) begin
            m_mode = 1; m_cur = m_init; m_step = 0;
          end else if (!bus_wdata[0] && old_mode != 0) begin
            m_mode = 0;
          end
        end else if (mi_a == 2 || mi_a == 3 || (mi_a >= 16 && mi_a < 32)) begin
          if (old_mode == 1) m_err = 1'b1;
          else if (mi_a == 2) m_init = int'(bus_wdata[3:0]);
          else if (mi_a == 3) m_halt = int'(bus_wdata[3:0]);
          else m_tbl[mi_a - 16] = int'(bus_wdata[15:0]);
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------------------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("bus_ready", {31'b0, bus_ready}, {31'b0, m_ready});
      check("fsm_state", {28'b0, fsm_state}, 32'(m_vis()));
      check("fsm_config_out", {28'b0, fsm_config_out}, 32'(m_cfg));
      check("running", {31'b0, running}, (m_mode == 1) ? 32'h1 : 32'h0);
      if (m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL scoreboard_empty: got rdata %h expected a queued entry", bus_rdata);
        end else begin
          check("bus_rdata", bus_rdata, exp_q.pop_front());
        end
      end else begin
        check("bus_rdata_idle", bus_rdata, 32'h0);
      end
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic rnd_event();
    if (rnd_ev) begin
      ev_valid = 1'($urandom_range(0, 1));
      ev_bit   = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic bus_access(input bit we, input logic [5:0] a, input logic [31:0] d,
                            output logic [31:0] r);
    bit got;
    @(negedge clk);
    bus_valid = 1'b1; bus_we = we; bus_addr = a; bus_wdata = d;
    rnd_event();
    got = 1'b0;
    r = 32'h0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (bus_ready) begin
        got = 1'b1;
        r = bus_rdata;
      end
      rnd_event();
    end
    bus_valid = 1'b0;
    check("bus_handshake", {31'b0, got}, 32'h1);
    $display("bus %s addr=%h wdata=%h rdata=%h", we ? "WR" : "RD", a, d, r);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus_access(1'b1, a, d, r);
  endtask

  task automatic send_ev(input bit b);
    @(negedge clk);
    ev_valid = 1'b1; ev_bit = b;
    @(negedge clk);
    ev_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    int op, idx;
    rst = 1'b1; bus_valid = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    ev_valid = 1'b0; ev_bit = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_state", {28'b0, fsm_state}, 32'h0);
    check("reset_cfg", {28'b0, fsm_config_out}, 32'h0);
    check("reset_running", {31'b0, running}, 32'h0);
    rst = 1'b0;

    // reset register values
    bus_access(1'b0, 6'h03, 32'h0, r); check("rst_halt_state", r, 32'h0000000F);
    bus_access(1'b0, 6'h01, 32'h0, r); check("rst_status", r, 32'h00000000);

    // two-step program to halt
    wr(6'h10, 32'h2131); wr(6'h11, 32'h4F53); wr(6'h02, 32'h0); wr(6'h03, 32'hF);
    wr(6'h00, 32'h1);
    check("run_started", {31'b0, running}, 32'h1);
    send_ev(1'b0);
    check("step1_state", {28'b0, fsm_state}, 32'h1);
    check("step1_cfg", {28'b0, fsm_config_out}, 32'h3);
    send_ev(1'b1);
    check("step2_state", {28'b0, fsm_state}, 32'hF);
    check("step2_cfg", {28'b0, fsm_config_out}, 32'h4);
    check("step2_running", {31'b0, running}, 32'h0);
    bus_access(1'b0, 6'h01, 32'h0, r); check("halt_status", r, 32'h0000022F);

    // write rejected while running
    wr(6'h00, 32'h0); wr(6'h12, 32'h1234); wr(6'h00, 32'h1); wr(6'h12, 32'hABCD);
    bus_access(1'b0, 6'h12, 32'h0, r); check("rejected_entry", r, 32'h00001234);
    bus_access(1'b0, 6'h01, 32'h0, r); check("wr_err_set", {31'b0, r[6]}, 32'h1);
    wr(6'h00, 32'h3);
    bus_access(1'b0, 6'h01, 32'h0, r);
    check("wr_err_clr", {31'b0, r[6]}, 32'h0);
    check("run_kept", {31'b0, r[4]}, 32'h1);

    // CTRL RUN=0 coincident with an event
    @(negedge clk);
    bus_valid = 1'b1; bus_we = 1'b1; bus_addr = 6'h00; bus_wdata = 32'h0;
    ev_valid = 1'b1; ev_bit = 1'b0;
    @(negedge clk);
    bus_valid = 1'b0; ev_valid = 1'b0;
    check("coinc_ready", {31'b0, bus_ready}, 32'h1);
    check("coinc_running", {31'b0, running}, 32'h0);
    check("coinc_state", {28'b0, fsm_state}, 32'h0);
    check("coinc_cfg", {28'b0, fsm_config_out}, 32'h4);

    // self-loop, 256 events wrap step_cnt
    wr(6'h10, 32'h0); wr(6'h03, 32'hF); wr(6'h02, 32'h0); wr(6'h00, 32'h3);
    for (int i = 0; i < 256; i++) send_ev(1'($urandom_range(0, 1)));
    bus_access(1'b0, 6'h01, 32'h0, r); check("wrap_status", r, 32'h00000010);

    // randomized traffic with background events
    rnd_ev = 1'b1;
    for (int i = 0; i < 400; i++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 3) begin
        bus_access(1'b0, 6'($urandom_range(0, 63)), 32'h0, r);
      end else if (op <= 6) begin
        idx = int'($urandom_range(0, 17));
        bus_access(1'b1, (idx == 0) ? 6'h02 : (idx == 1) ? 6'h03 : 6'(16 + idx - 2), $urandom, r);
      end else if (op == 7) begin
        bus_access(1'b1, 6'h00, ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3)), r);
      end else if (op == 8) begin
        bus_access(1'b1, 6'($urandom_range(0, 63)), $urandom, r);
      end else begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          rnd_event();
        end
      end
    end
    rnd_ev = 1'b0;
    @(negedge clk);
    ev_valid = 1'b0;

    // reset during a pending read while running
    wr(6'h00, 32'h0); wr(6'h00, 32'h1);
    check("pre_rst_running", {31'b0, running}, 32'h1);
    @(negedge clk);
    bus_valid = 1'b1; bus_we = 1'b0; bus_addr = 6'h01; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus_valid = 1'b0;
    check("abort_ready", {31'b0, bus_ready}, 32'h0);
    check("abort_rdata", bus_rdata, 32'h0);
    check("abort_state", {28'b0, fsm_state}, 32'h0);
    check("abort_cfg", {28'b0, fsm_config_out}, 32'h0);
    check("abort_running", {31'b0, running}, 32'h0);
    @(negedge clk);
    check("abort_no_late_ready", {31'b0, bus_ready}, 32'h0);
    bus_access(1'b0, 6'h03, 32'h0, r); check("abort_halt_state", r, 32'h0000000F);
    bus_access(1'b0, 6'h10, 32'h0, r); check("abort_table0", r, 32'h00000000);
    bus_access(1'b0, 6'h01, 32'h0, r); check("abort_status", r, 32'h00000000);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
